muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide controller in the EX stage, next to the ALU. It accepts one M-extension operation from decode and runs a shared radix-2 shift-add/shift-subtract datapath for a fixed number of cycles. It stalls the pipeline while it works and returns a 32-bit result with a single-cycle done pulse.

---
 rtl/muldiv_sequencer.sv | 176 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: 35-cycle latency (2 for special cases when MULDIV_EARLY_OUT_EN is defined).
// Holds stall_req while working; one op in flight, start ignored while busy, flush aborts without a done pulse.
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   input  logic            flush,
   output logic            busy,
   output logic            stall_req,
   output logic            done,
   output logic [XLEN-1:0] res
);

   typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIXUP, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [XLEN-1:0]     a_q, a_d;
   logic [XLEN-1:0]     b_q, b_d;
   logic [2*XLEN-1:0]   acc_q, acc_d;
   logic [5:0]          cnt_q, cnt_d;
   logic                s1_q, s1_d;
   logic                s2_q, s2_d;
   logic [XLEN-1:0]     res_q, res_d;

   logic                is_div, sgn1, sgn2;
   logic [XLEN:0]       mul_sum, div_rem_sh, div_diff;
   logic [2*XLEN-1:0]   prod;
   logic [XLEN-1:0]     q_fix, r_fix, fix_val;

`ifdef MULDIV_EARLY_OUT_EN
   localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
   logic                eo_div0, eo_ovf, eo_mz;
`endif

   assign is_div = op_q[2];
   assign sgn1   = (op_q == 3'd1) || (op_q == 3'd2) || (op_q == 3'd4) || (op_q == 3'd6);
   assign sgn2   = (op_q == 3'd1) || (op_q == 3'd4) || (op_q == 3'd6);

   // acc holds product high:multiplier-shifted-out for multiply, remainder:quotient for divide
   assign mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
   assign div_rem_sh = {acc_q[2*XLEN-1:XLEN], a_q[XLEN-1]};
   assign div_diff   = div_rem_sh - {1'b0, b_q};

   // Signed overflow needs no special handling here: |MIN|/1 = MIN and the signs cancel.
   assign prod  = (s1_q ^ s2_q) ? -acc_q : acc_q;
   assign q_fix = (s1_q ^ s2_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
   assign r_fix = s1_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

   always_comb begin
      fix_val = '0;
      case (op_q)
         3'd0:        fix_val = prod[XLEN-1:0];
         3'd1, 3'd2,
         3'd3:        fix_val = prod[2*XLEN-1:XLEN];
         3'd4, 3'd5:  fix_val = (b_q == '0) ? '1 : q_fix;
         default:     fix_val = r_fix;
      endcase
   end

`ifdef MULDIV_EARLY_OUT_EN
   assign eo_div0 = is_div && (b_q == '0);
   assign eo_ovf  = is_div && !op_q[0] && (a_q == SMIN) && (b_q == '1);
   assign eo_mz   = !is_div && ((a_q == '0) || (b_q == '0));
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      res_d   = res_q;

      if (flush && state_q != S_IDLE) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !flush) begin
                  op_d    = op;
                  a_d     = src1;
                  b_d     = src2;
                  state_d = S_PREP;
               end
            end
            S_PREP: begin
               s1_d    = sgn1 && a_q[XLEN-1];
               s2_d    = sgn2 && b_q[XLEN-1];
               a_d     = (sgn1 && a_q[XLEN-1]) ? -a_q : a_q;
               b_d     = (sgn2 && b_q[XLEN-1]) ? -b_q : b_q;
               acc_d   = '0;
               cnt_d   = 6'(XLEN - 1);
               state_d = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
               if (eo_div0 || eo_ovf || eo_mz) begin
                  if (eo_mz)
                     res_d = '0;
                  else if (eo_ovf)
                     res_d = op_q[1] ? '0 : SMIN;
                  else
                     res_d = op_q[1] ? a_q : '1;
                  state_d = S_DONE;
               end
`endif
            end
            S_CALC: begin
               if (is_div) begin
                  if (!div_diff[XLEN])
                     acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                  else
                     acc_d = {div_rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                  a_d = {a_q[XLEN-2:0], 1'b0};
               end else begin
                  if (b_q[0])
                     acc_d = {mul_sum, acc_q[XLEN-1:1]};
                  else
                     acc_d = {1'b0, acc_q[2*XLEN-1:1]};
                  b_d = {1'b0, b_q[XLEN-1:1]};
               end
               if (cnt_q == '0)
                  state_d = S_FIXUP;
               else
                  cnt_d = cnt_q - 6'd1;
            end
            S_FIXUP: begin
               res_d   = fix_val;
               state_d = S_DONE;
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         res_q   <= res_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign stall_req = (state_q == S_PREP) || (state_q == S_CALC) || (state_q == S_FIXUP) ||
                      ((state_q == S_IDLE) && start && !flush);
   assign done      = (state_q == S_DONE) && !flush;
   assign res       = res_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer: latency, result, stall and abort behaviour.
module tb_muldiv_sequencer;

`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_SP = 2;
`else
   localparam int LAT_SP = 35;
`endif
   localparam int LAT = 35;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] src1 = '0;
   logic [31:0] src2 = '0;
   logic        busy, stall_req, done;
   logic [31:0] res;

   int n_vec = 0;
   int n_err = 0;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .src1      (src1),
      .src2      (src2),
      .flush     (flush),
      .busy      (busy),
      .stall_req (stall_req),
      .done      (done),
      .res       (res)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Presents one request in IDLE, checks cycle-0 stall, returns in cycle 1.
   task automatic launch(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      src1  = a;
      src2  = b;
      #1;
      chk_eq({tag, "_stall0"}, 64'(stall_req), 64'd1);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int cyc;
      bit seen, stall_bad, busy_bad;
      cyc = 0; seen = 0; stall_bad = 0; busy_bad = 0;
      launch(tag, o, a, b);
      while (!seen && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (!busy) busy_bad = 1;
         if (stall_req == done) stall_bad = 1;
         if (done) seen = 1;
      end
      chk_eq({tag, "_lat"}, 64'(cyc), 64'(lat));
      chk_eq({tag, "_res"}, 64'(res), 64'(exp));
      chk_eq({tag, "_stall"}, 64'(stall_bad), 64'd0);
      chk_eq({tag, "_busy"}, 64'(busy_bad), 64'd0);
      @(negedge clk);
      chk_eq({tag, "_idle"}, {62'd0, done, busy}, 64'd0);
   endtask

   initial begin
      int n_done;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("rst_busy", 64'(busy), 64'd0);
      chk_eq("rst_done", 64'(done), 64'd0);
      chk_eq("rst_res", 64'(res), 64'd0);
      chk_eq("rst_stall", 64'(stall_req), 64'd0);
      rst = 1'b1;

      run_op("mul_7xm3",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);
      run_op("mul_shift",  3'd0, 32'h1234_5678,  32'h10,        32'h2345_6780, LAT);
      run_op("mulhu_ff",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
      run_op("mulh_ff",    3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         LAT);
      run_op("mulhsu_ff",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT);
      run_op("mul_zero",   3'd0, 32'd0,          32'd12345,     32'h0,         LAT_SP);
      run_op("div_m20_6",  3'd4, 32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFD, LAT);
      run_op("rem_m20_6",  3'd6, 32'hFFFF_FFEC,  32'd6,         32'hFFFF_FFFE, LAT);
      run_op("div_7_m2",   3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT);
      run_op("rem_7_m2",   3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         LAT);
      run_op("divu_5_0",   3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, LAT_SP);
      run_op("div_m7_0",   3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, LAT_SP);
      run_op("rem_m7_0",   3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, LAT_SP);
      run_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         LAT_SP);
      run_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, LAT_SP);
      run_op("remu_100_7", 3'd7, 32'd100,        32'd7,         32'd2,         LAT);
      run_op("divu_100_7", 3'd5, 32'd100,        32'd7,         32'd14,        LAT);

      // Flush during cycle 10 of a DIV.
      launch("flush_div", 3'd4, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk_eq("flush_busy", 64'(busy), 64'd0);
      chk_eq("flush_done", 64'(done), 64'd0);
      chk_eq("flush_res", 64'(res), 64'd14);
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk_eq("flush_nodone", 64'(n_done), 64'd0);

      // start together with flush in IDLE must not be accepted.
      @(negedge clk);
      start = 1'b1;
      flush = 1'b1;
      op    = 3'd4;
      src1  = 32'd50;
      src2  = 32'd5;
      #1;
      chk_eq("sf_stall", 64'(stall_req), 64'd0);
      @(posedge clk);
      #1;
      start = 1'b0;
      flush = 1'b0;
      chk_eq("sf_busy", 64'(busy), 64'd0);
      n_done = 0;
      repeat (40) begin
         @(negedge clk);
         if (done || busy) n_done++;
      end
      chk_eq("sf_nodone", 64'(n_done), 64'd0);
      chk_eq("sf_res", 64'(res), 64'd14);

      // Asynchronous reset in cycle 20 of a MUL.
      launch("rst_mul", 3'd0, 32'd3, 32'd9);
      repeat (20) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_eq("midrst_busy", 64'(busy), 64'd0);
      chk_eq("midrst_res", 64'(res), 64'd0);
      chk_eq("midrst_done", 64'(done), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      run_op("mul_4x5", 3'd0, 32'd4, 32'd5, 32'd20, LAT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
